// File: rtl/mem_dcache_req_pkg.sv
// Shared types for the MEM-stage data-cache request stage: FSM state
// encoding, the pipeline slot record and the "does this slot touch memory"
// predicate used by both the slot register and the FSM.
package mem_dcache_req_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_WEN_W  = MEM_DATA_W / 8;
    localparam int MEM_DST_W  = 5;

    typedef enum logic [2:0] {
        MREQ_IDLE,
        MREQ_REQ,
        MREQ_WAIT,
        MREQ_DONE,
        MREQ_DRAIN
    } MemReqState;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] addr;
        logic [MEM_WEN_W-1:0]  wen;
        logic [MEM_DATA_W-1:0] wdata;
        logic                  isload;
        logic [MEM_DST_W-1:0]  dst;
        logic                  regwr;
        logic                  except;
        logic                  valid;
    } MemSlotType;

    // An excepted instruction never touches memory; otherwise loads and
    // stores (any byte enable set) need a DCache access.
    function automatic logic needs_access(input logic                 except,
                                          input logic                 isload,
                                          input logic [MEM_WEN_W-1:0] wen);
        return ~except & (isload | (|wen));
    endfunction

endpackage

// File: rtl/mem_dcache_req_fsm.sv
// Request-tracking FSM for the MEM slot: sequences one DCache access at a
// time, absorbs responses orphaned by a flush, and decodes stall/done.
module mem_req_fsm
    import mem_dcache_req_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       wr,
    input  logic       slot_valid,
    input  logic       need_acc,
    input  logic       need_in,
    input  logic       slot_store,
    input  logic       req_ready,
    input  logic       resp_valid,
    output MemReqState state,
    output logic       req_valid,
    output logic       stall,
    output logic       done
);

    // State register; req_valid is registered alongside it and is high
    // exactly while the state is REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MREQ_IDLE;
            req_valid <= 1'b0;
        end else begin
            req_valid <= 1'b0;
            case (state)
                MREQ_IDLE: begin
                    if (!flush && need_acc) begin
                        state     <= MREQ_REQ;
                        req_valid <= 1'b1;
                    end
                end
                MREQ_REQ: begin
                    if (req_ready) begin
                        // A handshake on the flush edge still counts: the
                        // store commits, the load's response must be drained.
                        if (flush)
                            state <= slot_store ? MREQ_IDLE : MREQ_DRAIN;
                        else
                            state <= slot_store ? MREQ_DONE : MREQ_WAIT;
                    end else if (flush) begin
                        state <= MREQ_IDLE;
                    end else begin
                        req_valid <= 1'b1;
                    end
                end
                MREQ_WAIT: begin
                    if (flush)
                        state <= resp_valid ? MREQ_IDLE : MREQ_DRAIN;
                    else if (resp_valid)
                        state <= MREQ_DONE;
                end
                MREQ_DONE: begin
                    if (flush) begin
                        state <= MREQ_IDLE;
                    end else if (wr) begin
                        state     <= need_in ? MREQ_REQ : MREQ_IDLE;
                        req_valid <= need_in;
                    end
                end
                MREQ_DRAIN: begin
                    if (resp_valid) begin
                        if (flush) begin
                            state <= MREQ_IDLE;
                        end else if (wr) begin
                            state     <= need_in ? MREQ_REQ : MREQ_IDLE;
                            req_valid <= need_in;
                        end else begin
                            state     <= need_acc ? MREQ_REQ : MREQ_IDLE;
                            req_valid <= need_acc;
                        end
                    end
                end
                default: state <= MREQ_IDLE;
            endcase
        end
    end

    // Stall while the slot's access is outstanding, or while an orphaned
    // response is still due and a new slot is waiting behind it.
    always_comb begin
        stall = (need_acc && state != MREQ_DONE) ||
                (state == MREQ_DRAIN && slot_valid);
        done  = (state == MREQ_DONE) ||
                (slot_valid && !need_acc && state != MREQ_DRAIN);
    end

endmodule

// File: rtl/mem_dcache_req.sv
// MEM-stage data-cache request stage: holds the slot latched from EXE,
// drives the DCache request from it, captures load data and exports the
// forwarding value/destination back to EXE. Slot widths follow the package.
module mem_dcache_req
    import mem_dcache_req_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int WEN_W  = MEM_WEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_Flush,
    input  logic              MEM_Wr,
    input  logic [DATA_W-1:0] EXE_ALUOut,
    input  logic [WEN_W-1:0]  EXE_DCache_Wen,
    input  logic [DATA_W-1:0] EXE_DataToDcache,
    input  logic              EXE_IsLoad,
    input  logic [4:0]        EXE_Dst,
    input  logic              EXE_RegWr,
    input  logic              EXE_ExceptValid,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [DATA_W-1:0] req_addr,
    output logic [WEN_W-1:0]  req_wen,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_rdata,
    output logic [DATA_W-1:0] MEM_Result,
    output logic [4:0]        MEM_Dst,
    output logic              MEM_RegWr,
    output logic [DATA_W-1:0] MEM_LoadData,
    output logic              MEM_Done,
    output logic              MEM_Stall
);

    MemSlotType slot;
    MemReqState state;
    logic       need_acc;
    logic       need_in;

    // Slot register: reset beats flush beats a new load from EXE. A flush
    // only kills validity and the write flag so forwarding fields linger.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
        end else if (MEM_Flush) begin
            slot.valid <= 1'b0;
            slot.regwr <= 1'b0;
        end else if (MEM_Wr) begin
            slot <= '{addr:   EXE_ALUOut,
                      wen:    EXE_DCache_Wen,
                      wdata:  EXE_DataToDcache,
                      isload: EXE_IsLoad,
                      dst:    EXE_Dst,
                      regwr:  EXE_RegWr,
                      except: EXE_ExceptValid,
                      valid:  1'b1};
        end
    end

    // Load data is captured only for a live slot; responses that arrive
    // during a flush or in DRAIN belong to a killed instruction.
    always_ff @(posedge clk) begin
        if (rst)
            MEM_LoadData <= '0;
        else if (state == MREQ_WAIT && resp_valid && !MEM_Flush)
            MEM_LoadData <= resp_rdata;
    end

    // Access predicates for the held slot and for the slot arriving from EXE.
    always_comb begin
        need_acc = slot.valid & needs_access(slot.except, slot.isload, slot.wen);
        need_in  = needs_access(EXE_ExceptValid, EXE_IsLoad, EXE_DCache_Wen);
    end

    // Request fields come straight from the slot, which cannot change while
    // the request is pending because the stall holds MEM_Wr off.
    always_comb begin
        req_addr   = slot.addr;
        req_wen    = slot.wen;
        req_wdata  = slot.wdata;
        MEM_Result = slot.addr;
        MEM_Dst    = slot.dst;
        MEM_RegWr  = slot.regwr & slot.valid;
    end

    mem_req_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .flush      (MEM_Flush),
        .wr         (MEM_Wr),
        .slot_valid (slot.valid),
        .need_acc   (need_acc),
        .need_in    (need_in),
        .slot_store (|slot.wen),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .state      (state),
        .req_valid  (req_valid),
        .stall      (MEM_Stall),
        .done       (MEM_Done)
    );

endmodule

// File: tb/tb_mem_dcache_req.sv
// Directed bench for mem_dcache_req: a cycle-by-cycle vector table covering
// ALU/excepted slots, loads, DRAIN after flush and flush in REQ, followed by
// hand-written sequences for a stalled store and reset during WAIT.
module tb_mem_dcache_req;

    logic        clk;
    logic        rst;
    logic        MEM_Flush;
    logic        MEM_Wr;
    logic [31:0] EXE_ALUOut;
    logic [3:0]  EXE_DCache_Wen;
    logic [31:0] EXE_DataToDcache;
    logic        EXE_IsLoad;
    logic [4:0]  EXE_Dst;
    logic        EXE_RegWr;
    logic        EXE_ExceptValid;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_wen;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [31:0] MEM_Result;
    logic [4:0]  MEM_Dst;
    logic        MEM_RegWr;
    logic [31:0] MEM_LoadData;
    logic        MEM_Done;
    logic        MEM_Stall;

    int checks = 0;
    int errors = 0;

    mem_dcache_req dut (
        .clk              (clk),
        .rst              (rst),
        .MEM_Flush        (MEM_Flush),
        .MEM_Wr           (MEM_Wr),
        .EXE_ALUOut       (EXE_ALUOut),
        .EXE_DCache_Wen   (EXE_DCache_Wen),
        .EXE_DataToDcache (EXE_DataToDcache),
        .EXE_IsLoad       (EXE_IsLoad),
        .EXE_Dst          (EXE_Dst),
        .EXE_RegWr        (EXE_RegWr),
        .EXE_ExceptValid  (EXE_ExceptValid),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_wen          (req_wen),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .MEM_Result       (MEM_Result),
        .MEM_Dst          (MEM_Dst),
        .MEM_RegWr        (MEM_RegWr),
        .MEM_LoadData     (MEM_LoadData),
        .MEM_Done         (MEM_Done),
        .MEM_Stall        (MEM_Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl, wr;
        logic [31:0] alu;
        logic [3:0]  wen;
        logic [31:0] wd;
        logic        ld;
        logic [4:0]  dst;
        logic        rw, ex, rdy, rv;
        logic [31:0] rd;
        logic        e_req, e_stall, e_done;
        logic [31:0] e_res;
        logic [4:0]  e_dst;
        logic        e_rw;
        logic [31:0] e_ld;
    } vec_t;

    function automatic vec_t mk(input logic fl, input logic wr, input logic [31:0] alu,
                                input logic [3:0] wen, input logic [31:0] wd, input logic ld,
                                input logic [4:0] dst, input logic rw, input logic ex,
                                input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic e_req, input logic e_stall, input logic e_done,
                                input logic [31:0] e_res, input logic [4:0] e_dst,
                                input logic e_rw, input logic [31:0] e_ld);
        vec_t v;
        v.fl = fl; v.wr = wr; v.alu = alu; v.wen = wen; v.wd = wd; v.ld = ld;
        v.dst = dst; v.rw = rw; v.ex = ex; v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.e_req = e_req; v.e_stall = e_stall; v.e_done = e_done; v.e_res = e_res;
        v.e_dst = e_dst; v.e_rw = e_rw; v.e_ld = e_ld;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        MEM_Flush        = v.fl;
        MEM_Wr           = v.wr;
        EXE_ALUOut       = v.alu;
        EXE_DCache_Wen   = v.wen;
        EXE_DataToDcache = v.wd;
        EXE_IsLoad       = v.ld;
        EXE_Dst          = v.dst;
        EXE_RegWr        = v.rw;
        EXE_ExceptValid  = v.ex;
        req_ready        = v.rdy;
        resp_valid       = v.rv;
        resp_rdata       = v.rd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " req_valid"}, {31'b0, req_valid}, 32'h0);
        chk({tag, " req_addr"},  req_addr, 32'h0);
        chk({tag, " req_wen"},   {28'b0, req_wen}, 32'h0);
        chk({tag, " req_wdata"}, req_wdata, 32'h0);
        chk({tag, " result"},    MEM_Result, 32'h0);
        chk({tag, " dst"},       {27'b0, MEM_Dst}, 32'h0);
        chk({tag, " regwr"},     {31'b0, MEM_RegWr}, 32'h0);
        chk({tag, " loaddata"},  MEM_LoadData, 32'h0);
        chk({tag, " done"},      {31'b0, MEM_Done}, 32'h0);
        chk({tag, " stall"},     {31'b0, MEM_Stall}, 32'h0);
    endtask

    vec_t vt[23];
    vec_t idle_v;

    initial begin
        // fl wr alu wen wd ld dst rw ex | rdy rv rd | req stall done res dst rw ld
        vt[0]  = mk(0,1,32'h100,4'hF,32'h55,0,3,1,1, 0,0,0,          0,0,1,32'h100,3,1,32'h0);
        vt[1]  = mk(0,0,0,0,0,0,0,0,0,               0,0,0,          0,0,1,32'h100,3,1,32'h0);
        vt[2]  = mk(0,1,32'h200,4'h0,0,1,5,1,0,      1,0,0,          0,1,0,32'h200,5,1,32'h0);
        vt[3]  = mk(0,0,0,0,0,0,0,0,0,               1,0,0,          1,1,0,32'h200,5,1,32'h0);
        vt[4]  = mk(0,0,0,0,0,0,0,0,0,               1,0,0,          0,1,0,32'h200,5,1,32'h0);
        vt[5]  = mk(0,0,0,0,0,0,0,0,0,               0,1,32'hDEADBEEF,0,0,1,32'h200,5,1,32'hDEADBEEF);
        vt[6]  = mk(0,1,32'h204,4'h0,0,1,6,1,0,      0,0,0,          1,1,0,32'h204,6,1,32'hDEADBEEF);
        vt[7]  = mk(0,0,0,0,0,0,0,0,0,               1,0,0,          0,1,0,32'h204,6,1,32'hDEADBEEF);
        vt[8]  = mk(0,0,0,0,0,0,0,0,0,               0,1,32'h12345678,0,0,1,32'h204,6,1,32'h12345678);
        vt[9]  = mk(0,1,32'h300,4'h0,0,1,7,1,0,      0,0,0,          1,1,0,32'h300,7,1,32'h12345678);
        vt[10] = mk(0,0,0,0,0,0,0,0,0,               1,0,0,          0,1,0,32'h300,7,1,32'h12345678);
        vt[11] = mk(1,0,0,0,0,0,0,0,0,               0,0,0,          0,0,0,32'h300,7,0,32'h12345678);
        vt[12] = mk(0,1,32'h304,4'h0,0,1,8,1,0,      0,0,0,          0,1,0,32'h304,8,1,32'h12345678);
        vt[13] = mk(0,0,0,0,0,0,0,0,0,               0,0,0,          0,1,0,32'h304,8,1,32'h12345678);
        vt[14] = mk(0,0,0,0,0,0,0,0,0,               0,1,32'hBAD0BAD0,1,1,0,32'h304,8,1,32'h12345678);
        vt[15] = mk(0,0,0,0,0,0,0,0,0,               1,0,0,          0,1,0,32'h304,8,1,32'h12345678);
        vt[16] = mk(0,0,0,0,0,0,0,0,0,               0,1,32'hCAFEF00D,0,0,1,32'h304,8,1,32'hCAFEF00D);
        vt[17] = mk(0,1,32'h400,4'h0,0,1,9,1,0,      0,0,0,          1,1,0,32'h400,9,1,32'hCAFEF00D);
        vt[18] = mk(1,0,0,0,0,0,0,0,0,               0,0,0,          0,0,0,32'h400,9,0,32'hCAFEF00D);
        vt[19] = mk(0,0,0,0,0,0,0,0,0,               0,0,0,          0,0,0,32'h400,9,0,32'hCAFEF00D);
        vt[20] = mk(0,1,32'h500,4'hF,32'hA5A5A5A5,0,0,0,0, 1,0,0,    0,1,0,32'h500,0,0,32'hCAFEF00D);
        vt[21] = mk(0,0,0,0,0,0,0,0,0,               1,0,0,          1,1,0,32'h500,0,0,32'hCAFEF00D);
        vt[22] = mk(0,0,0,0,0,0,0,0,0,               1,0,0,          0,0,1,32'h500,0,0,32'hCAFEF00D);
        idle_v = mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0);

        // Reset state
        drive(idle_v);
        rst = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // Table: each row's inputs are applied across one edge, then the
        // registered outputs are compared just after that edge.
        for (int i = 0; i < 23; i++) begin
            drive(vt[i]);
            tick();
            chk($sformatf("v%0d req_valid", i), {31'b0, req_valid}, {31'b0, vt[i].e_req});
            chk($sformatf("v%0d stall", i),     {31'b0, MEM_Stall}, {31'b0, vt[i].e_stall});
            chk($sformatf("v%0d done", i),      {31'b0, MEM_Done},  {31'b0, vt[i].e_done});
            chk($sformatf("v%0d result", i),    MEM_Result,         vt[i].e_res);
            chk($sformatf("v%0d dst", i),       {27'b0, MEM_Dst},   {27'b0, vt[i].e_dst});
            chk($sformatf("v%0d regwr", i),     {31'b0, MEM_RegWr}, {31'b0, vt[i].e_rw});
            chk($sformatf("v%0d loaddata", i),  MEM_LoadData,       vt[i].e_ld);
        end

        // Store issued from DONE with req_ready low for three cycles: the
        // request must stay asserted with stable fields until accepted.
        drive(idle_v);
        MEM_Wr           = 1'b1;
        EXE_ALUOut       = 32'h8000_0010;
        EXE_DCache_Wen   = 4'b0011;
        EXE_DataToDcache = 32'h0000_BEEF;
        EXE_Dst          = 5'd4;
        tick();
        MEM_Wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("st%0d req_valid", i), {31'b0, req_valid}, 32'h1);
            chk($sformatf("st%0d addr", i),      req_addr, 32'h8000_0010);
            chk($sformatf("st%0d wen", i),       {28'b0, req_wen}, 32'h3);
            chk($sformatf("st%0d wdata", i),     req_wdata, 32'h0000_BEEF);
            chk($sformatf("st%0d stall", i),     {31'b0, MEM_Stall}, 32'h1);
            req_ready = (i == 3);
            tick();
        end
        req_ready = 1'b0;
        chk("st_hs req_valid", {31'b0, req_valid}, 32'h0);
        chk("st_hs stall",     {31'b0, MEM_Stall}, 32'h0);
        chk("st_hs done",      {31'b0, MEM_Done},  32'h1);

        // Reset while a load waits for its response; the late response must
        // be ignored afterwards.
        drive(idle_v);
        MEM_Wr         = 1'b1;
        EXE_ALUOut     = 32'h600;
        EXE_IsLoad     = 1'b1;
        EXE_Dst        = 5'd10;
        EXE_RegWr      = 1'b1;
        req_ready      = 1'b1;
        tick();
        MEM_Wr = 1'b0;
        chk("rw req_valid", {31'b0, req_valid}, 32'h1);
        tick();
        req_ready = 1'b0;
        chk("rw wait req_valid", {31'b0, req_valid}, 32'h0);
        chk("rw wait stall",     {31'b0, MEM_Stall}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("rst_wait");
        resp_valid = 1'b1;
        resp_rdata = 32'h77;
        tick();
        resp_valid = 1'b0;
        chk("stray loaddata",  MEM_LoadData, 32'h0);
        chk("stray done",      {31'b0, MEM_Done}, 32'h0);
        chk("stray req_valid", {31'b0, req_valid}, 32'h0);
        tick();
        chk("stray2 req_valid", {31'b0, req_valid}, 32'h0);
        chk("stray2 stall",     {31'b0, MEM_Stall}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
